// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory bus between instruction fetch (IF) and load/store (LS); one outstanding transaction, round-robin on ties.
// Latency: req sampled in IDLE -> mem_valid next cycle -> ack the cycle after the bus response (minimum 2 cycles req-to-ack).
// Backpressure: mem_ready stalls the address phase, mem_rvalid the response; requesters hold req until ack; busy high outside IDLE.
// Optional feature: define MEM_ARB_TIMEOUT_EN to enable a bus watchdog of TIMEOUT_CYCLES that acks with err=1 and rdata=0.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_strb,
  output logic                ls_ack,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_err,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_strb,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_RESP = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  // 1 = most recent grant went to LS; while a transaction is open it also names the owner
  logic                last_ls_q, last_ls_d;
  logic                mem_valid_q, mem_valid_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]   mem_strb_q, mem_strb_d;
  logic                if_ack_q, if_ack_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                if_err_q, if_err_d;
  logic                ls_ack_q, ls_ack_d;
  logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
  logic                ls_err_q, ls_err_d;
  logic                busy_q, busy_d;

  logic                grant_ls;
  logic                complete;
  logic                expire;

`ifdef MEM_ARB_TIMEOUT_EN
  // counter holds 0..TIMEOUT_CYCLES-1; the last value marks the final allowed wait cycle
  localparam int              CNT_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // next-state and next-output computation for the arbiter FSM
  always_comb begin
    state_d     = state_q;
    last_ls_d   = last_ls_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_strb_d  = mem_strb_q;
    if_ack_d    = 1'b0;
    if_rdata_d  = '0;
    if_err_d    = 1'b0;
    ls_ack_d    = 1'b0;
    ls_rdata_d  = '0;
    ls_err_d    = 1'b0;
    grant_ls    = 1'b0;
    complete    = 1'b0;
    expire      = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (if_req || ls_req) begin
          // a tie goes to whichever port did not win last time
          grant_ls    = ls_req && (!if_req || !last_ls_q);
          last_ls_d   = grant_ls;
          state_d     = S_ADDR;
          mem_valid_d = 1'b1;
          if (grant_ls) begin
            mem_we_d    = ls_we;
            mem_addr_d  = ls_addr;
            mem_wdata_d = ls_wdata;
            mem_strb_d  = ls_strb;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_strb_d  = '1;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      S_ADDR: begin
        if (mem_ready && mem_rvalid) begin
          complete = 1'b1;
        end else if (mem_ready) begin
          state_d     = S_RESP;
          mem_valid_d = 1'b0;
        end
      end
      S_RESP: begin
        complete = mem_rvalid;
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef MEM_ARB_TIMEOUT_EN
    // a real completion in the limit cycle takes priority over the watchdog
    if (state_q == S_ADDR || state_q == S_RESP) begin
      cnt_d  = cnt_q + 1'b1;
      expire = !complete && (cnt_q == CNT_LAST);
    end
`endif

    if (complete || expire) begin
      state_d     = S_ACK;
      mem_valid_d = 1'b0;
      if (last_ls_q) begin
        ls_ack_d   = 1'b1;
        ls_rdata_d = complete ? mem_rdata : '0;
        ls_err_d   = expire;
      end else begin
        if_ack_d   = 1'b1;
        if_rdata_d = complete ? mem_rdata : '0;
        if_err_d   = expire;
      end
    end
  end

  assign busy_d = (state_d != S_IDLE);

  // state and registered outputs; reset abandons any open transaction without an ack
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      last_ls_q   <= 1'b1;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_strb_q  <= '0;
      if_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      ls_ack_q    <= 1'b0;
      ls_rdata_q  <= '0;
      ls_err_q    <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_ls_q   <= last_ls_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_strb_q  <= mem_strb_d;
      if_ack_q    <= if_ack_d;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_err_d;
      ls_ack_q    <= ls_ack_d;
      ls_rdata_q  <= ls_rdata_d;
      ls_err_q    <= ls_err_d;
      busy_q      <= busy_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_strb  = mem_strb_q;
  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign ls_ack    = ls_ack_q;
  assign ls_rdata  = ls_rdata_q;
  assign ls_err    = ls_err_q;
  assign busy      = busy_q;

endmodule
